// File: rtl/data_mem_bus.sv
// data_mem_bus: data-side memory bus for a small RV32 core.
// Decodes CPU loads/stores onto a byte-addressed data RAM, an LED register,
// a UART transmit queue drained by a small FSM, and UART RX/status registers.
// Optional feature: define DATA_MEM_BUS_TIMER_EN to add a 32-bit free-running
// cycle counter readable/writable at 0x2000_0004.
module data_mem_bus #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned TXQ_DEPTH = 8,
    parameter int unsigned LED_W     = 16,
    parameter string       INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      addr,
    input  logic [2:0]       func3,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    output logic             misalign,
    output logic [LED_W-1:0] led,
    output logic [7:0]       uart_tx_data,
    output logic             uart_tx_we,
    input  logic             uart_tx_busy,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_rx_valid,
    output logic             uart_rx_re
);

    localparam int unsigned WORDS = MEM_BYTES / 4;
    localparam int unsigned WA_W  = $clog2(WORDS);
    localparam int unsigned PTR_W = $clog2(TXQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;
    localparam logic [31:0] LED_ADDR       = 32'h2000_0000;
    localparam logic [31:0] RAM_LIMIT      = 32'(MEM_BYTES);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_HOLD,
        TX_WAIT
    } txState_e;

    // Storage and state registers
    logic [31:0]      mem_q [WORDS];
    logic [7:0]       txq_q [TXQ_DEPTH];
    logic [PTR_W-1:0] txWrPtr_q, txRdPtr_q;
    logic [CNT_W-1:0] txCount_q, txCount_d;
    logic             txOvf_q;
    txState_e         txState_q, txState_d;
    logic [31:0]      rdata_q;
    logic             rvalid_q;
    logic             misalign_q;
    logic [LED_W-1:0] led_q;
    logic [7:0]       txData_q;

    // Request decode
    logic            isLoad, isStore;
    logic            loadValid, storeValid;
    logic            loadMis, storeMis, storeOk;
    logic            ramHit, hitUartData, hitUartStat, hitLed;
    logic [WA_W-1:0] wordIdx;
    logic [31:0]     readWord, loadResult;
    logic [7:0]      laneByte;
    logic [15:0]     laneHalf;
    logic            ramWe;
    logic [3:0]      ramBe;
    logic [31:0]     ramWdata;

    // TX queue control
    logic txFull, txEmpty, txPending;
    logic pushReq, txPush, txDrop, txPop, loadTxData;

`ifdef DATA_MEM_BUS_TIMER_EN
    localparam logic [31:0] TIMER_ADDR = 32'h2000_0004;
    logic        hitTimer;
    logic [31:0] timer_q;
    assign hitTimer = (addr == TIMER_ADDR);
`endif

    assign isLoad      = mem_read & ~mem_write;
    assign isStore     = mem_write & ~mem_read;
    assign ramHit      = (addr < RAM_LIMIT);
    assign hitUartData = (addr == UART_DATA_ADDR);
    assign hitUartStat = (addr == UART_STAT_ADDR);
    assign hitLed      = (addr == LED_ADDR);
    assign wordIdx     = addr[WA_W+1:2];

    // Classify the access width and flag faulting alignments
    always_comb begin
        loadValid  = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                     (func3 == F3_BU) || (func3 == F3_HU);
        storeValid = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
        loadMis    = isLoad && (((func3 == F3_W) && (addr[1:0] != 2'b00)) ||
                                (((func3 == F3_H) || (func3 == F3_HU)) && addr[0]));
        storeMis   = isStore && (((func3 == F3_W) && (addr[1:0] != 2'b00)) ||
                                 ((func3 == F3_H) && addr[0]));
        storeOk    = isStore && storeValid && !storeMis;
    end

    // Select the 32-bit word the addressed region presents to a load
    always_comb begin
        readWord = '0;
        if (ramHit) begin
            readWord = mem_q[wordIdx];
        end else if (hitUartData) begin
            readWord = {24'b0, uart_rx_data};
        end else if (hitUartStat) begin
            readWord = {28'b0, txOvf_q, txFull, txPending, uart_rx_valid};
        end else if (hitLed) begin
            readWord = 32'(led_q);
`ifdef DATA_MEM_BUS_TIMER_EN
        end else if (hitTimer) begin
            readWord = timer_q;
`endif
        end
    end

    // Extract the addressed byte/half lane and extend it according to func3
    always_comb begin
        case (addr[1:0])
            2'd0:    laneByte = readWord[7:0];
            2'd1:    laneByte = readWord[15:8];
            2'd2:    laneByte = readWord[23:16];
            default: laneByte = readWord[31:24];
        endcase
        laneHalf = addr[1] ? readWord[31:16] : readWord[15:0];
        case (func3)
            F3_B:    loadResult = {{24{laneByte[7]}}, laneByte};
            F3_H:    loadResult = {{16{laneHalf[15]}}, laneHalf};
            F3_W:    loadResult = readWord;
            F3_BU:   loadResult = {24'b0, laneByte};
            F3_HU:   loadResult = {16'b0, laneHalf};
            default: loadResult = '0;
        endcase
        if (loadMis) begin
            loadResult = '0;
        end
    end

    // Register the load result, its valid pulse and the fault pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            rvalid_q   <= isLoad;
            misalign_q <= loadMis | storeMis;
            if (isLoad) begin
                rdata_q <= loadResult;
            end
        end
    end

    // Build byte enables and replicated write data for RAM stores
    always_comb begin
        ramWe    = storeOk && ramHit && !rst;
        ramBe    = 4'b0000;
        ramWdata = wdata;
        case (func3)
            F3_B: begin
                ramBe    = 4'b0001 << addr[1:0];
                ramWdata = {4{wdata[7:0]}};
            end
            F3_H: begin
                ramBe    = addr[1] ? 4'b1100 : 4'b0011;
                ramWdata = {2{wdata[15:0]}};
            end
            F3_W: begin
                ramBe    = 4'b1111;
            end
            default: begin
                ramBe    = 4'b0000;
            end
        endcase
    end

    // Data RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (ramBe[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= ramWdata[8*b +: 8];
                end
            end
        end
    end

    // LED register, written by any valid store width
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else if (storeOk && hitLed) begin
            led_q <= wdata[LED_W-1:0];
        end
    end

`ifdef DATA_MEM_BUS_TIMER_EN
    // Free-running cycle counter; a store overrides the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (storeOk && hitTimer) begin
            timer_q <= wdata;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end
`endif

    assign txFull    = (txCount_q == CNT_W'(TXQ_DEPTH));
    assign txEmpty   = (txCount_q == '0);
    assign txPending = !txEmpty || (txState_q != TX_IDLE) || uart_tx_busy;
    assign pushReq   = storeOk && hitUartData;
    assign txPush    = pushReq && (!txFull || txPop);
    assign txDrop    = pushReq && txFull && !txPop;

    // Queue occupancy follows push minus pop
    always_comb begin
        txCount_d = txCount_q;
        if (txPush && !txPop) begin
            txCount_d = txCount_q + CNT_W'(1);
        end else if (txPop && !txPush) begin
            txCount_d = txCount_q - CNT_W'(1);
        end
    end

    // Queue pointers and occupancy; pointers wrap at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            txWrPtr_q <= '0;
            txRdPtr_q <= '0;
            txCount_q <= '0;
        end else begin
            txCount_q <= txCount_d;
            if (txPush) begin
                txWrPtr_q <= txWrPtr_q + PTR_W'(1);
            end
            if (txPop) begin
                txRdPtr_q <= txRdPtr_q + PTR_W'(1);
            end
        end
    end

    // Queue byte storage
    always_ff @(posedge clk) begin
        if (txPush) begin
            txq_q[txWrPtr_q] <= wdata[7:0];
        end
    end

    // Sticky overflow flag; a same-cycle overflow beats a software clear
    always_ff @(posedge clk) begin
        if (rst) begin
            txOvf_q <= 1'b0;
        end else if (txDrop) begin
            txOvf_q <= 1'b1;
        end else if (storeOk && hitUartStat && wdata[3]) begin
            txOvf_q <= 1'b0;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            txState_q <= TX_IDLE;
        end else begin
            txState_q <= txState_d;
        end
    end

    // Drain FSM next state; ISSUE pops the head, entering ISSUE latches it
    always_comb begin
        txState_d  = txState_q;
        txPop      = 1'b0;
        loadTxData = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                if (!txEmpty && !uart_tx_busy) begin
                    txState_d  = TX_ISSUE;
                    loadTxData = 1'b1;
                end
            end
            TX_ISSUE: begin
                txPop     = 1'b1;
                txState_d = TX_HOLD;
            end
            TX_HOLD: begin
                txState_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!uart_tx_busy) begin
                    txState_d = TX_IDLE;
                end
            end
            default: begin
                txState_d = TX_IDLE;
            end
        endcase
    end

    // Byte presented to the UART, held after the write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            txData_q <= '0;
        end else if (loadTxData) begin
            txData_q <= txq_q[txRdPtr_q];
        end
    end

    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign misalign     = misalign_q;
    assign led          = led_q;
    assign uart_tx_data = txData_q;
    assign uart_tx_we   = (txState_q == TX_ISSUE);
    assign uart_rx_re   = !rst && isLoad && loadValid && hitUartData;

endmodule
